screen_frame_tx: RTL and testbench

// - Upstream sequencer for the screen UART byte transmitter. Holds one command frame and feeds it byte-by-byte.
// - Frame on the wire: HDR0, HDR1, LEN, CMD, payload[0..N-1], optional CHK.
// - Drives the transmitter's data/strobe pair, paced by its tx_finish status.

---
 rtl/screen_frame_if.sv | 38 +++
 rtl/screen_frame_tx.sv | 189 ++++++++++++++++++
 tb/tb_screen_frame_tx.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/screen_frame_if.sv
// screen_frame_if
//   Bundles the frame request, payload-buffer write port and transmitter
//   handshake of screen_frame_tx.
//   master : frame requester / transmitter side (drives start, cmd,
//            payload_len, wr_*, tx_finish; observes the rest)
//   slave  : screen_frame_tx itself
//   Signals:
//     start, cmd[7:0], payload_len[4:0]   frame request
//     wr_en, wr_addr[ADDR_W-1:0], wr_data payload buffer write port
//     tx_finish                           transmitter idle status
//     data_out[7:0], data_flash           byte and strobe to the transmitter
//     busy, done, err                     frame status
interface screen_frame_if #(
  parameter int ADDR_W = 4
);
  logic              start;
  logic [7:0]        cmd;
  logic [4:0]        payload_len;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              tx_finish;
  logic [7:0]        data_out;
  logic              data_flash;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, cmd, payload_len, wr_en, wr_addr, wr_data, tx_finish,
    input  data_out, data_flash, busy, done, err
  );

  modport slave (
    input  start, cmd, payload_len, wr_en, wr_addr, wr_data, tx_finish,
    output data_out, data_flash, busy, done, err
  );
endinterface

// File: rtl/screen_frame_tx.sv
// screen_frame_tx
//   Holds one command frame and feeds it byte-by-byte to the screen UART
//   transmitter: HDR0, HDR1, LEN, CMD, payload[0..len-1], optional CHK.
//   Each byte is presented on data_out, then data_flash is raised one clock
//   later and held until the transmitter drops tx_finish. The next byte is
//   loaded GAP_CYCLES clocks after tx_finish returns high.
//   Ports:
//     clk    system clock
//     rst_n  asynchronous active-low reset
//     bus    screen_frame_if.slave (request, buffer write, tx handshake,
//            busy/done/err status)
//   Build option: define SCREEN_FRAME_CHK_EN to append the CHK byte
//   (8-bit wrap-around sum of CMD and payload); LEN then counts it too.
module screen_frame_tx #(
  parameter int         MAX_LEN     = 16,
  parameter int         ADDR_W      = 4,
  parameter logic [7:0] HDR0        = 8'h5A,
  parameter logic [7:0] HDR1        = 8'hA5,
  parameter int         GAP_CYCLES  = 16,
  parameter int         ACK_TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          rst_n,
  screen_frame_if.slave bus
);

`ifdef SCREEN_FRAME_CHK_EN
  localparam logic CHK_ON = 1'b1;
`else
  localparam logic CHK_ON = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_STROBE, S_WAIT_ACK, S_WAIT_DONE, S_GAP, S_DONE
  } state_t;

  state_t      state_reg;
  logic [7:0]  pay_mem [MAX_LEN];
  logic [7:0]  cmd_reg;
  logic [4:0]  len_reg;
  logic [5:0]  idx_reg;
  logic [15:0] ack_cnt_reg;
  logic [15:0] gap_cnt_reg;
  logic [7:0]  data_out_reg;
  logic        flash_reg;
  logic        busy_reg;
  logic        done_reg;
  logic        err_reg;
`ifdef SCREEN_FRAME_CHK_EN
  logic [7:0]  sum_reg;
`endif

  logic [5:0]        pay_end;   // index of first byte after the payload
  logic [5:0]        last_idx;  // index of the final byte of the frame
  logic [ADDR_W-1:0] pay_idx;
  logic [7:0]        len_byte;
  logic [7:0]        cur_byte;
  logic              last_byte;

  assign pay_end   = 6'd4 + {1'b0, len_reg};
  assign last_idx  = pay_end - 6'd1 + {5'd0, CHK_ON};
  assign pay_idx   = ADDR_W'(idx_reg - 6'd4);
  assign len_byte  = {3'd0, len_reg} + 8'd1 + {7'd0, CHK_ON};
  assign last_byte = (idx_reg == last_idx);

  // Byte selected by the running index; only consumed in LOAD.
  always_comb begin
    cur_byte = 8'h00;
    if (idx_reg == 6'd0)      cur_byte = HDR0;
    else if (idx_reg == 6'd1) cur_byte = HDR1;
    else if (idx_reg == 6'd2) cur_byte = len_byte;
    else if (idx_reg == 6'd3) cur_byte = cmd_reg;
    else if (idx_reg < pay_end) cur_byte = pay_mem[pay_idx];
`ifdef SCREEN_FRAME_CHK_EN
    else cur_byte = sum_reg;
`endif
  end

  // Payload buffer: locked against writes while a frame is being sent so
  // the bytes cannot change underneath the sequencer.
  always_ff @(posedge clk) begin
    if (bus.wr_en && !busy_reg) pay_mem[bus.wr_addr] <= bus.wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      cmd_reg      <= 8'h00;
      len_reg      <= 5'd0;
      idx_reg      <= 6'd0;
      ack_cnt_reg  <= 16'd0;
      gap_cnt_reg  <= 16'd0;
      data_out_reg <= 8'h00;
      flash_reg    <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
`ifdef SCREEN_FRAME_CHK_EN
      sum_reg      <= 8'h00;
`endif
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (bus.start) begin
            if (32'(bus.payload_len) > 32'(MAX_LEN)) begin
              err_reg <= 1'b1;
            end else begin
              cmd_reg   <= bus.cmd;
              len_reg   <= bus.payload_len;
              idx_reg   <= 6'd0;
              busy_reg  <= 1'b1;
              state_reg <= S_LOAD;
`ifdef SCREEN_FRAME_CHK_EN
              sum_reg   <= 8'h00;
`endif
            end
          end
        end
        S_LOAD: begin
          data_out_reg <= cur_byte;
`ifdef SCREEN_FRAME_CHK_EN
          // CMD and payload bytes contribute to the checksum.
          if (idx_reg >= 6'd3 && idx_reg < pay_end) sum_reg <= sum_reg + cur_byte;
`endif
          state_reg <= S_STROBE;
        end
        S_STROBE: begin
          flash_reg   <= 1'b1;
          ack_cnt_reg <= 16'd0;
          state_reg   <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (!bus.tx_finish) begin
            flash_reg <= 1'b0;
            state_reg <= S_WAIT_DONE;
          end else if (ack_cnt_reg == 16'(ACK_TIMEOUT - 1)) begin
            // Transmitter never took the byte: abandon the frame.
            flash_reg <= 1'b0;
            err_reg   <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= S_IDLE;
          end else begin
            ack_cnt_reg <= ack_cnt_reg + 16'd1;
          end
        end
        S_WAIT_DONE: begin
          if (bus.tx_finish) begin
            if (GAP_CYCLES == 0) begin
              if (last_byte) state_reg <= S_DONE;
              else begin
                idx_reg   <= idx_reg + 6'd1;
                state_reg <= S_LOAD;
              end
            end else begin
              gap_cnt_reg <= 16'd0;
              state_reg   <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt_reg == 16'(GAP_CYCLES - 1)) begin
            if (last_byte) state_reg <= S_DONE;
            else begin
              idx_reg   <= idx_reg + 6'd1;
              state_reg <= S_LOAD;
            end
          end else begin
            gap_cnt_reg <= gap_cnt_reg + 16'd1;
          end
        end
        S_DONE: begin
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign bus.data_out   = data_out_reg;
  assign bus.data_flash = flash_reg;
  assign bus.busy       = busy_reg;
  assign bus.done       = done_reg;
  assign bus.err        = err_reg;

endmodule

// File: tb/tb_screen_frame_tx.sv
// tb_screen_frame_tx
//   Directed bench for screen_frame_tx with a behavioural UART transmitter:
//   tx_finish drops 3 clocks after a data_flash rising edge and returns high
//   40 clocks (10 bit-times of 4 clocks) later. Expected frames follow the
//   SCREEN_FRAME_CHK_EN build option.
module tb_screen_frame_tx;
  localparam int ACK_T = 1024;
  localparam int GAP   = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  screen_frame_if #(.ADDR_W(4)) bus ();

  screen_frame_tx #(
    .MAX_LEN(16), .ADDR_W(4), .HDR0(8'h5A), .HDR1(8'hA5),
    .GAP_CYCLES(GAP), .ACK_TIMEOUT(ACK_T)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  typedef struct {
    logic [7:0]   cmd;
    logic [4:0]   len;
    logic [127:0] pay;  // byte i at [8*i +: 8]
    logic [167:0] exp;  // wire order written left to right, right-aligned
    int           n;
    bit           exp_err;
  } vec_t;

  vec_t vecs[5];

  int n_cmp = 0;
  int n_bad = 0;

  // Monitor state
  logic [7:0] rx_q[$];
  int edge_cnt = 0, done_cnt = 0, err_cnt = 0;
  int flash_hi_cnt = 0, busy_hi_cnt = 0, stab_bad = 0;
  logic mon_prev = 1'b0;
  bit tie_high = 1'b0;
  logic m_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Samples DUT outputs 1 time unit after each active edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bus.data_flash && !mon_prev) begin
        rx_q.push_back(bus.data_out);
        edge_cnt++;
      end
      if (bus.data_flash && rx_q.size() > 0 && bus.data_out !== rx_q[rx_q.size()-1]) stab_bad++;
      mon_prev = bus.data_flash;
      if (bus.done) done_cnt++;
      if (bus.err) err_cnt++;
      if (bus.data_flash) flash_hi_cnt++;
      if (bus.busy) busy_hi_cnt++;
    end
  end

  // Transmitter model.
  initial begin
    bus.tx_finish = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bus.data_flash && !m_prev && !tie_high) begin
        repeat (3) @(posedge clk);
        #1 bus.tx_finish = 1'b0;
        repeat (40) @(posedge clk);
        #1 bus.tx_finish = 1'b1;
      end
      m_prev = bus.data_flash;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    rx_q.delete();
    edge_cnt = 0; done_cnt = 0; err_cnt = 0;
    flash_hi_cnt = 0; busy_hi_cnt = 0; stab_bad = 0;
  endtask

  task automatic write_payload(input int v);
    for (int i = 0; i < int'(vecs[v].len) && i < 16; i++) begin
      bus.wr_en = 1'b1;
      bus.wr_addr = 4'(i);
      bus.wr_data = vecs[v].pay[8*i +: 8];
      tick();
    end
    bus.wr_en = 1'b0;
  endtask

  task automatic run_vec(input int v, input bit do_write, input bit poke);
    vec_t t;
    int cyc;
    bit busy_drop;
    bit poked;
    logic [7:0] act, expb;
    t = vecs[v];
    if (do_write) write_payload(v);
    clear_mon();
    bus.cmd = t.cmd;
    bus.payload_len = t.len;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    cyc = 0;
    busy_drop = 1'b0;
    poked = 1'b0;
    while (done_cnt == 0 && err_cnt == 0 && cyc < 4000) begin
      if (!t.exp_err && !bus.busy) busy_drop = 1'b1;
      if (poke && !poked && edge_cnt == 2) begin
        // start and buffer write while busy must both be ignored
        bus.start = 1'b1; bus.cmd = 8'h77; bus.payload_len = 5'd1;
        bus.wr_en = 1'b1; bus.wr_addr = 4'd1; bus.wr_data = 8'hEE;
        tick();
        bus.start = 1'b0; bus.wr_en = 1'b0;
        poked = 1'b1;
      end else begin
        tick();
      end
      cyc++;
    end
    check($sformatf("v%0d_finished_in_time", v), 32'(cyc < 4000), 32'd1);
    repeat (20) tick();
    check($sformatf("v%0d_byte_count", v), 32'(rx_q.size()), 32'(t.n));
    for (int k = 0; k < t.n; k++) begin
      expb = t.exp[8*(t.n-1-k) +: 8];
      act = (k < rx_q.size()) ? rx_q[k] : 8'hxx;
      check($sformatf("v%0d_byte%0d", v, k), 32'(act), 32'(expb));
    end
    check($sformatf("v%0d_done_pulses", v), 32'(done_cnt), t.exp_err ? 32'd0 : 32'd1);
    check($sformatf("v%0d_err_pulses", v), 32'(err_cnt), t.exp_err ? 32'd1 : 32'd0);
    check($sformatf("v%0d_busy_after", v), 32'(bus.busy), 32'd0);
    if (t.exp_err) check($sformatf("v%0d_busy_never", v), 32'(busy_hi_cnt), 32'd0);
    else check($sformatf("v%0d_busy_held", v), 32'(busy_drop), 32'd0);
    check($sformatf("v%0d_data_stable", v), 32'(stab_bad), 32'd0);
    $display("frame v%0d cmd=%02h len=%0d: %0d bytes, done=%0d err=%0d",
             v, t.cmd, t.len, rx_q.size(), done_cnt, err_cnt);
  endtask

  initial begin
    int cyc;
    bus.start = 1'b0; bus.cmd = 8'h00; bus.payload_len = 5'd0;
    bus.wr_en = 1'b0; bus.wr_addr = 4'd0; bus.wr_data = 8'h00;

    // Vector table: expected bytes hand-computed.
    vecs[0] = '{cmd: 8'h83, len: 5'd2, pay: 128'({8'h22, 8'h11}), exp: '0, n: 0, exp_err: 1'b0};
    vecs[1] = '{cmd: 8'hF0, len: 5'd2, pay: 128'({8'h05, 8'h20}), exp: '0, n: 0, exp_err: 1'b0};
    vecs[2] = '{cmd: 8'h01, len: 5'd0, pay: '0, exp: '0, n: 0, exp_err: 1'b0};
    vecs[3] = '{cmd: 8'h55, len: 5'd17, pay: '0, exp: '0, n: 0, exp_err: 1'b1};
    vecs[4] = '{cmd: 8'h40, len: 5'd16, pay: {16{8'h10}}, exp: '0, n: 0, exp_err: 1'b0};
`ifdef SCREEN_FRAME_CHK_EN
    vecs[0].exp = 168'({8'h5A, 8'hA5, 8'h04, 8'h83, 8'h11, 8'h22, 8'hB6}); vecs[0].n = 7;
    vecs[1].exp = 168'({8'h5A, 8'hA5, 8'h04, 8'hF0, 8'h20, 8'h05, 8'h15}); vecs[1].n = 7;
    vecs[2].exp = 168'({8'h5A, 8'hA5, 8'h02, 8'h01, 8'h01}); vecs[2].n = 5;
    vecs[4].exp = {8'h5A, 8'hA5, 8'h12, 8'h40, {16{8'h10}}, 8'h40}; vecs[4].n = 21;
`else
    vecs[0].exp = 168'({8'h5A, 8'hA5, 8'h03, 8'h83, 8'h11, 8'h22}); vecs[0].n = 6;
    vecs[1].exp = 168'({8'h5A, 8'hA5, 8'h03, 8'hF0, 8'h20, 8'h05}); vecs[1].n = 6;
    vecs[2].exp = 168'({8'h5A, 8'hA5, 8'h01, 8'h01}); vecs[2].n = 4;
    vecs[4].exp = 168'({8'h5A, 8'hA5, 8'h11, 8'h40, {16{8'h10}}}); vecs[4].n = 20;
`endif

    // Reset state
    repeat (3) tick();
    check("rst_data_out", 32'(bus.data_out), 32'd0);
    check("rst_data_flash", 32'(bus.data_flash), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();
    check("post_rst_busy", 32'(bus.busy), 32'd0);

    for (int v = 0; v < 5; v++) run_vec(v, 1'b1, v == 0);

    // Ack timeout: transmitter never answers.
    write_payload(0);
    clear_mon();
    tie_high = 1'b1;
    bus.cmd = 8'h83; bus.payload_len = 5'd2; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    cyc = 0;
    while (err_cnt == 0 && cyc < 3000) begin tick(); cyc++; end
    check("to_finished_in_time", 32'(cyc < 3000), 32'd1);
    check("to_flash_high_clks", 32'(flash_hi_cnt), 32'(ACK_T));
    check("to_err_pulses", 32'(err_cnt), 32'd1);
    check("to_busy", 32'(bus.busy), 32'd0);
    check("to_flash_low", 32'(bus.data_flash), 32'd0);
    check("to_edges", 32'(edge_cnt), 32'd1);
    check("to_first_byte", 32'((rx_q.size() > 0) ? rx_q[0] : 8'hxx), 32'h5A);
    repeat (5) tick();
    check("to_err_width", 32'(err_cnt), 32'd1);
    check("to_no_done", 32'(done_cnt), 32'd0);
    $display("timeout frame: flash high %0d clks, err=%0d busy=%0d", flash_hi_cnt, err_cnt, bus.busy);
    tie_high = 1'b0;
    repeat (3) tick();

    // Mid-frame asynchronous reset after the third byte.
    write_payload(0);
    clear_mon();
    bus.cmd = 8'h83; bus.payload_len = 5'd2; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    cyc = 0;
    while (edge_cnt < 3 && cyc < 1000) begin tick(); cyc++; end
    check("mr_reached_byte3", 32'(edge_cnt), 32'd3);
    bus.start = 1'b1; bus.wr_en = 1'b1; bus.wr_addr = 4'd0; bus.wr_data = 8'hEE;
    tick();
    bus.start = 1'b0; bus.wr_en = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("mr_data_out", 32'(bus.data_out), 32'd0);
    check("mr_data_flash", 32'(bus.data_flash), 32'd0);
    check("mr_busy", 32'(bus.busy), 32'd0);
    check("mr_done", 32'(bus.done), 32'd0);
    check("mr_err", 32'(bus.err), 32'd0);
    $display("mid-frame reset after %0d bytes: outputs cleared", edge_cnt);
    tick();
    rst_n = 1'b1;
    cyc = 0;
    while (bus.tx_finish !== 1'b1 && cyc < 200) begin tick(); cyc++; end
    check("mr_tx_idle", 32'(bus.tx_finish), 32'd1);
    repeat (3) tick();
    // Buffer must still hold 11 22 (busy-time write to addr 0 ignored).
    run_vec(0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
